// File: rtl/urt_samp_pkg.sv
// Shared constants and helpers for the parametrised UART RX data sampler.
package urt_samp_pkg;

  localparam int   URT_MIN_PRESCALE = 4;
  localparam int   URT_MAX_PRESCALE = 32;
  localparam logic URT_LINE_IDLE    = 1'b1;

  // Majority vote over the lowest n bits of samples (n is 3 or 5).
  function automatic logic urt_majority(input logic [4:0] samples, input int n);
    int ones;
    ones = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < n && samples[i]) ones++;
    end
    return (ones > (n / 2));
  endfunction

  // Prescale must be a power of two in 4..32 and leave room for the whole
  // n-sample window (centre+K) inside one bit period.
  function automatic logic urt_prescale_legal(input logic [31:0] prescale, input int n);
    logic pow2_ok;
    pow2_ok = 1'b0;
    for (int p = URT_MIN_PRESCALE; p <= URT_MAX_PRESCALE; p = p * 2) begin
      if (prescale == 32'(p)) pow2_ok = 1'b1;
    end
    return pow2_ok && (((prescale >> 1) + 32'((n - 1) / 2)) <= (prescale - 32'd1));
  endfunction

endpackage

// File: rtl/urt_rx_sync.sv
// Metastability synchroniser for the asynchronous serial line.
// SYNC_STAGES=0 gives a direct connection; flops reset to the idle level.
module urt_rx_sync
  import urt_samp_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  if (SYNC_STAGES == 0) begin : g_direct
    assign dout = din;
  end else begin : g_chain
    logic [SYNC_STAGES-1:0] chain_q;

    // Shift the line through the flop chain, idle-high out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        chain_q <= {SYNC_STAGES{URT_LINE_IDLE}};
      end else begin
        chain_q[0] <= din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          chain_q[i] <= chain_q[i-1];
        end
      end
    end

    assign dout = chain_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/data_samp_urt_rx_param.sv
// Parametrised oversampling data sampler for the UART RX path.
// Takes NUM_SAMPLES (3 or 5) samples centred on the bit midpoint for any
// power-of-two prescale 4..32, then issues a majority vote with a one-cycle
// valid strobe and a noise flag.
// Optional macro URT_SAMP_NOISE_CNT_EN adds a saturating noisy-vote counter
// (noise_cnt_SAMP) with a synchronous clear input (noise_clr_SAMP).
module data_samp_urt_rx_param
  import urt_samp_pkg::*;
#(
  parameter int PRESC_W     = 6,
  parameter int NUM_SAMPLES = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK_SAMP,
  input  logic               RST_SAMP,
  input  logic [PRESC_W-1:0] Prescale_SAMP,
  input  logic               RX_IN_SAMP,
  input  logic               dat_samp_en_SAMP,
  input  logic [PRESC_W-1:0] edge_cnt_SAMP,
  output logic               sampled_bit_SAMP,
  output logic               sample_valid_SAMP,
  output logic               noise_err_SAMP,
  output logic               prescale_err_SAMP
`ifdef URT_SAMP_NOISE_CNT_EN
  ,
  input  logic               noise_clr_SAMP,
  output logic [7:0]         noise_cnt_SAMP
`endif
);

  localparam int K = (NUM_SAMPLES - 1) / 2;
  localparam logic [NUM_SAMPLES-1:0] LAST_BIT = {1'b1, {(NUM_SAMPLES-1){1'b0}}};
  localparam logic [NUM_SAMPLES-1:0] ALL_ONES = '1;

  if (NUM_SAMPLES != 3 && NUM_SAMPLES != 5) begin : g_bad_samples
    $error("data_samp_urt_rx_param: NUM_SAMPLES must be 3 or 5");
  end
  if (PRESC_W < 6) begin : g_bad_width
    $error("data_samp_urt_rx_param: PRESC_W must be at least 6");
  end

  logic                   rx_sync;
  logic [PRESC_W-1:0]     centre;
  logic [PRESC_W-1:0]     win_start;
  logic [PRESC_W-1:0]     win_end;
  logic [PRESC_W-1:0]     win_idx;
  logic [PRESC_W-1:0]     presc_q;
  logic                   presc_bad;
  logic                   presc_chg;
  logic                   block;
  logic                   in_win;
  logic                   at_last;
  logic                   capture;
  logic                   vote_fire;
  logic                   vote_bit;
  logic                   vote_noisy;
  logic                   pend_q;
  logic [NUM_SAMPLES-1:0] samp_q;
  logic [NUM_SAMPLES-1:0] mask_q;

  urt_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (CLK_SAMP),
    .rst_n(RST_SAMP),
    .din  (RX_IN_SAMP),
    .dout (rx_sync)
  );

  assign centre     = Prescale_SAMP >> 1;
  assign win_start  = centre - PRESC_W'(K);
  assign win_end    = centre + PRESC_W'(K);
  assign win_idx    = edge_cnt_SAMP - win_start;
  assign presc_bad  = !urt_prescale_legal(32'(Prescale_SAMP), NUM_SAMPLES);
  assign presc_chg  = (Prescale_SAMP != presc_q);
  assign block      = presc_bad || prescale_err_SAMP;
  assign in_win     = (edge_cnt_SAMP >= win_start) && (edge_cnt_SAMP <= win_end);
  assign at_last    = (edge_cnt_SAMP == win_end);
  assign capture    = dat_samp_en_SAMP && !block && !presc_chg && in_win;
  assign vote_fire  = pend_q && dat_samp_en_SAMP && !block;
  assign vote_bit   = urt_majority(5'(samp_q), NUM_SAMPLES);
  assign vote_noisy = (samp_q != '0) && (samp_q != ALL_ONES);

  // Store the synchronised line into the sample slot matching this edge.
  always_ff @(posedge CLK_SAMP or negedge RST_SAMP) begin
    if (!RST_SAMP) begin
      samp_q <= {NUM_SAMPLES{URT_LINE_IDLE}};
    end else begin
      for (int i = 0; i < NUM_SAMPLES; i++) begin
        if (capture && win_idx == PRESC_W'(i)) samp_q[i] <= rx_sync;
      end
    end
  end

  // Track which slots hold fresh samples; arm a vote only on a full window.
  always_ff @(posedge CLK_SAMP or negedge RST_SAMP) begin
    if (!RST_SAMP) begin
      mask_q  <= '0;
      pend_q  <= 1'b0;
      presc_q <= PRESC_W'(URT_MIN_PRESCALE);
    end else begin
      presc_q <= Prescale_SAMP;
      pend_q  <= 1'b0;
      if (!dat_samp_en_SAMP || block || presc_chg) begin
        mask_q <= '0;
      end else if (at_last) begin
        mask_q <= '0;
        pend_q <= &(mask_q | LAST_BIT);
      end else if (in_win) begin
        for (int i = 0; i < NUM_SAMPLES; i++) begin
          if (win_idx == PRESC_W'(i)) mask_q[i] <= 1'b1;
        end
      end
    end
  end

  // Publish the vote, the strobe, the noise flag and the prescale check.
  always_ff @(posedge CLK_SAMP or negedge RST_SAMP) begin
    if (!RST_SAMP) begin
      sampled_bit_SAMP  <= URT_LINE_IDLE;
      sample_valid_SAMP <= 1'b0;
      noise_err_SAMP    <= 1'b0;
      prescale_err_SAMP <= 1'b0;
    end else begin
      prescale_err_SAMP <= presc_bad;
      sample_valid_SAMP <= vote_fire;
      if (!dat_samp_en_SAMP) begin
        sampled_bit_SAMP <= URT_LINE_IDLE;
        noise_err_SAMP   <= 1'b0;
      end else if (block) begin
        sampled_bit_SAMP <= URT_LINE_IDLE;
      end else if (vote_fire) begin
        sampled_bit_SAMP <= vote_bit;
        noise_err_SAMP   <= vote_noisy;
      end
    end
  end

`ifdef URT_SAMP_NOISE_CNT_EN
  // Count noisy votes, saturating at 255; clear has priority over increment.
  always_ff @(posedge CLK_SAMP or negedge RST_SAMP) begin
    if (!RST_SAMP) begin
      noise_cnt_SAMP <= 8'd0;
    end else if (noise_clr_SAMP) begin
      noise_cnt_SAMP <= 8'd0;
    end else if (vote_fire && vote_noisy && noise_cnt_SAMP != 8'hFF) begin
      noise_cnt_SAMP <= noise_cnt_SAMP + 8'd1;
    end
  end
`endif

endmodule
